pulse_decoder_3to8: RTL and testbench
=====================================

// Module: pulse_decoder_3to8
// PURPOSE
//  Receive side of the 8-to-3 priority encoder interface: accepts an encoded
//  {valid, 3-bit code} on a valid/ready handshake.
//  Expands each accepted code to a one-hot 8-bit output pulse held for HOLD
//  cycles, followed by a GAP-cycle quiet period.
//  Sits downstream of the priority encoder to drive per-line grant/strobe lines
//  from an encoded request stream.
// PARAMETERS
//  HOLD  4  cycles each one-hot output is held; legal 1..255, 0 is an elaboration error
//  GAP   1  quiet cycles (out==0) after each hold; legal 0..255
// PORTS
//  clk       in   1  single clock, all logic rising-edge
//  rst       in   1  synchronous, active-high reset
//  in_valid  in   1  source presents a code; must stay high until accepted
//  in_code   in   3  encoded line index, sampled only on acceptance
//  in_ready  out  1  block can accept; acceptance = in_valid & in_ready at a clk edge
//  out       out  8  one-hot decoded output; 8'h00 when not in HOLD
//  busy      out  1  high in HOLD or GAP
//  done      out  1  one-cycle pulse on the last HOLD cycle
//  hit_cnt   out 16  [PULSE_DEC_HIT_CNT_EN only] accepted-code count
// BEHAVIOUR
//  Reset: state=IDLE, out=8'h00, busy=0, done=0, in_ready=1 (combinational from IDLE),
//   internal counter=0, hit_cnt=0; all take effect at the edge where rst=1.
//  FSM states:
//   - IDLE: in_ready=1, out=0. On acceptance: latch code, cnt<=HOLD-1, go to HOLD.
//   - HOLD: out=1<<code, busy=1. cnt decrements each cycle.
//     When cnt==0: done=1 this cycle; next state is GAP (cnt<=GAP-1) if GAP>0, else IDLE.
//   - GAP: out=0, busy=1. cnt decrements; when cnt==0, go to IDLE.
//  Latency: code accepted at edge N -> out valid on cycles N+1..N+HOLD exactly.
//  Next acceptance is earliest at edge N+HOLD+GAP+1 (IDLE lasts at least one cycle,
//   so out has at least one zero cycle between pulses even when GAP=0).
//  Readiness: in_ready is 0 in HOLD/GAP (no skid buffer).
//   in_code changes while not ready are ignored; the latched code is stable for the whole HOLD.
//  Output form: out is registered, never glitches, and is always one-hot or zero;
//   code 3'd0 gives 8'h01.
//  Counter: 8-bit down-counter sized for 255; no wrap is reachable with legal params.
//  Reset mid-HOLD/GAP: out drops to 0 at that edge, done is suppressed,
//   and the in-flight code is discarded.
//  in_valid during reset is not accepted; acceptance is earliest at the first edge with rst=0.
// CONFIGURATION
//  PULSE_DEC_HIT_CNT_EN defined:
//   - hit_cnt port exists; increments by 1 on each acceptance.
//   - Saturates at 16'hFFFF (no wrap); cleared by rst.
//  Not defined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package pulse_dec_pkg:
//   - typedef enum logic [1:0] {IDLE, HOLD, GAP} pulse_dec_state_t
//   - localparam CODE_W=3, OUT_W=8
//   - function onehot8(code)
//  Sub-module pulse_dec_cnt: loadable 8-bit down-counter with load, en, zero flag.
//   Instantiated once, shared by HOLD and GAP.
// TESTING
//  1. rst=1 for 2 cycles with in_valid=1, code=5
//     -> out=00, busy=0, done=0, in_ready=1, no acceptance until rst=0.
//  2. HOLD=4, GAP=1: accept code=3 at edge N
//     -> out=8'h08 on N+1..N+4, done only on N+4, out=0 on N+5, in_ready=1 on N+6.
//  3. Back-to-back in_valid codes 7 then 0
//     -> 8'h80 for HOLD cycles, GAP zeros, one IDLE cycle, then 8'h01.
//     in_code toggled during HOLD has no effect.
//  4. GAP=0, HOLD=1: stream of 8 codes 0..7
//     -> each line pulses once for 1 cycle, separated by one zero cycle; done on every pulse.
//  5. rst asserted on 2nd HOLD cycle of code=6
//     -> out=0 at that edge, no done, next code is accepted normally after release.
//  6. PULSE_DEC_HIT_CNT_EN: preload near saturation via 65535 accepts
//     -> hit_cnt holds at 16'hFFFF; rst clears it to 0.
//     Without the macro, the build has no hit_cnt port.

Source files
------------

// File: rtl/pulse_dec_pkg.sv
// Shared types and helpers for the 3-to-8 pulse decoder.
// Optional hit counter in the top is enabled by defining PULSE_DEC_HIT_CNT_EN.
package pulse_dec_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } pulse_dec_state_t;

    function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pulse_dec_cnt.sv
// Loadable 8-bit down-counter shared by the HOLD and GAP phases.
// Load has priority over decrement; zero flag is combinational from the count.
module pulse_dec_cnt
    import pulse_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_decoder_3to8.sv
// Expands each accepted 3-bit code into a registered one-hot pulse of HOLD cycles
// followed by GAP quiet cycles. Define PULSE_DEC_HIT_CNT_EN to add the hit_cnt port.
module pulse_decoder_3to8
    import pulse_dec_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              done
`ifdef PULSE_DEC_HIT_CNT_EN
    ,
    output logic [15:0]       hit_cnt
`endif
);

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("pulse_decoder_3to8: HOLD must be 1..255");
    end
    if (GAP < 0 || GAP > 255) begin : g_bad_gap
        $error("pulse_decoder_3to8: GAP must be 0..255");
    end

    // Parameter names shadow the HOLD/GAP enum literals, so alias them here.
    localparam pulse_dec_state_t S_HOLD  = pulse_dec_pkg::HOLD;
    localparam pulse_dec_state_t S_GAP   = pulse_dec_pkg::GAP;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    pulse_dec_state_t    state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                cnt_load;
    logic                cnt_en;
    logic [CNT_W-1:0]    cnt_ld_val;
    logic                cnt_zero;

    pulse_dec_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_ld_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_ld_val = HOLD_LD;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    code_d   = in_code;
                    cnt_load = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    if (GAP > 0) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = GAP_LD;
                        state_d    = S_GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Output is computed from the next state so the pulse is a clean register.
        out_d = (state_d == S_HOLD) ? onehot8(code_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            out_q   <= out_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == S_HOLD) && cnt_zero;
    assign out      = out_q;

`ifdef PULSE_DEC_HIT_CNT_EN
    logic [15:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (in_valid && in_ready && hit_q != 16'hFFFF) begin
            hit_d = hit_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_pulse_decoder_3to8.sv
// Self-checking bench for pulse_decoder_3to8: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked every cycle against a schedule model; PULSE_DEC_HIT_CNT_EN adds hit_cnt checks.
module tb_pulse_decoder_3to8;

    localparam int HA = 4, GA = 1;
    localparam int HB = 1, GB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       va, vb;
    logic [2:0] ca, cb;
    logic       ra, rb, ba, bb, da, db;
    logic [7:0] oa, ob;
`ifdef PULSE_DEC_HIT_CNT_EN
    logic [15:0] hit_a, hit_b;
`endif

    pulse_decoder_3to8 #(.HOLD(HA), .GAP(GA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_code(ca), .in_ready(ra),
        .out(oa), .busy(ba), .done(da)
`ifdef PULSE_DEC_HIT_CNT_EN
        , .hit_cnt(hit_a)
`endif
    );

    pulse_decoder_3to8 #(.HOLD(HB), .GAP(GB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_code(cb), .in_ready(rb),
        .out(ob), .busy(bb), .done(db)
`ifdef PULSE_DEC_HIT_CNT_EN
        , .hit_cnt(hit_b)
`endif
    );

    // Model: an accepted code owns the periods acc .. acc+HOLD+GAP-1 after its acceptance edge.
    typedef struct {
        bit       act;
        int       acc;
        logic [2:0] code;
    } mdl_t;

    mdl_t ma = '{0, 0, 3'd0};
    mdl_t mb = '{0, 0, 3'd0};
    int   cyc = 0;
    int   hit_ma = 0, hit_mb = 0;
    int   total = 0, bad = 0;

    function automatic bit m_busy(mdl_t m, int h, int g, int k);
        return m.act && ((k - m.acc) < (h + g));
    endfunction

    function automatic logic [7:0] m_out(mdl_t m, int h, int k);
        if (m.act && (k - m.acc) < h) return 8'(1 << m.code);
        return 8'h00;
    endfunction

    function automatic bit m_done(mdl_t m, int h, int k);
        return m.act && ((k - m.acc) == h - 1);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ma.act <= 1'b0;
            mb.act <= 1'b0;
            hit_ma <= 0;
            hit_mb <= 0;
        end else begin
            if (va && !m_busy(ma, HA, GA, cyc)) begin
                ma.act  <= 1'b1;
                ma.acc  <= cyc + 1;
                ma.code <= ca;
                hit_ma  <= (hit_ma == 65535) ? hit_ma : hit_ma + 1;
            end
            if (vb && !m_busy(mb, HB, GB, cyc)) begin
                mb.act  <= 1'b1;
                mb.acc  <= cyc + 1;
                mb.code <= cb;
                hit_mb  <= (hit_mb == 65535) ? hit_mb : hit_mb + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        check("a_out",   16'(oa), 16'(m_out(ma, HA, cyc)));
        check("a_busy",  16'(ba), 16'(m_busy(ma, HA, GA, cyc)));
        check("a_ready", 16'(ra), 16'(!m_busy(ma, HA, GA, cyc)));
        check("a_done",  16'(da), 16'(m_done(ma, HA, cyc)));
        check("b_out",   16'(ob), 16'(m_out(mb, HB, cyc)));
        check("b_busy",  16'(bb), 16'(m_busy(mb, HB, GB, cyc)));
        check("b_ready", 16'(rb), 16'(!m_busy(mb, HB, GB, cyc)));
        check("b_done",  16'(db), 16'(m_done(mb, HB, cyc)));
`ifdef PULSE_DEC_HIT_CNT_EN
        check("a_hit", hit_a, 16'(hit_ma));
        check("b_hit", hit_b, 16'(hit_mb));
`endif
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!m_busy(ma, HA, GA, cyc) && !m_busy(mb, HB, GB, cyc)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("wait_idle_timeout", 16'd1, 16'd0);
    endtask

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] e2_out  [6] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
    logic       e2_done [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       e2_rdy  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] e3_out  [10] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00,
                                 8'h01, 8'h01, 8'h01, 8'h01};
    logic [2:0] e3_tog  [10] = '{3'd5, 3'd2, 3'd6, 3'd1, 3'd0, 3'd0,
                                 3'd4, 3'd3, 3'd7, 3'd2};

    initial begin
        vecs[0] = '{3'd0, 8'h01};
        vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04};
        vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10};
        vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40};
        vecs[7] = '{3'd7, 8'h80};

        // Reset held two cycles with a pending code: nothing may be accepted.
        rst = 1'b1; va = 1'b1; ca = 3'd5; vb = 1'b1; cb = 3'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_out",   16'(oa), 16'h0000);
            check("rst_busy",  16'(ba), 16'h0000);
            check("rst_done",  16'(da), 16'h0000);
            check("rst_ready", 16'(ra), 16'h0001);
        end
        rst = 1'b0;
        tick();
        check("first_accept_a", 16'(oa), 16'h0020);
        check("first_accept_b", 16'(ob), 16'h0020);
        va = 1'b0; vb = 1'b0;

        // Single code 3 on the HOLD=4/GAP=1 instance, cycle by cycle.
        wait_idle();
        va = 1'b1; ca = 3'd3;
        tick();
        va = 1'b0; ca = 3'd0;
        for (int i = 0; i < 6; i++) begin
            check("seq2_out",   16'(oa), 16'(e2_out[i]));
            check("seq2_done",  16'(da), 16'(e2_done[i]));
            check("seq2_ready", 16'(ra), 16'(e2_rdy[i]));
            tick();
        end

        // Back-to-back 7 then 0 with in_code toggling while busy.
        wait_idle();
        va = 1'b1; ca = 3'd7;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("seq3_out", 16'(oa), 16'(e3_out[i]));
            if (i < 6) ca = e3_tog[i];
            if (i >= 6) va = 1'b0;
            tick();
        end
        va = 1'b0;

        // HOLD=1/GAP=0 stream of all eight codes.
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            vb = 1'b1; cb = vecs[i].code;
            tick();
            check("vec_out",  16'(ob), 16'(vecs[i].exp_out));
            check("vec_done", 16'(db), 16'h0001);
            vb = 1'b0;
            tick();
            check("vec_gap", 16'(ob), 16'h0000);
        end

        // Reset on the second HOLD cycle of code 6, then a normal code.
        wait_idle();
        va = 1'b1; ca = 3'd6;
        tick();
        va = 1'b0;
        tick();
        check("mid_hold_out", 16'(oa), 16'h0040);
        rst = 1'b1;
        tick();
        check("rst_mid_out",  16'(oa), 16'h0000);
        check("rst_mid_done", 16'(da), 16'h0000);
        check("rst_mid_busy", 16'(ba), 16'h0000);
        rst = 1'b0; va = 1'b1; ca = 3'd2;
        tick();
        check("post_rst_out", 16'(oa), 16'h0004);
        va = 1'b0;

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            va  = ($urandom_range(0, 2) != 0);
            vb  = ($urandom_range(0, 2) != 0);
            ca  = 3'($urandom);
            cb  = 3'($urandom);
            tick();
        end
        rst = 1'b0; va = 1'b0; vb = 1'b0;
        repeat (8) tick();

`ifdef PULSE_DEC_HIT_CNT_EN
        rst = 1'b1;
        tick();
        check("hit_clear", hit_b, 16'h0000);
        rst = 1'b0;
        vb = 1'b1;
        for (int i = 0; i < 65540 * 2; i++) begin
            cb = 3'($urandom);
            tick();
        end
        vb = 1'b0;
        check("hit_sat", hit_b, 16'hFFFF);
        rst = 1'b1;
        tick();
        check("hit_rst", hit_b, 16'h0000);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
